// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and I/O address map for the io_bridge slice
package io_bridge_pkg;

    typedef logic [7:0]  BYTE_TP;
    typedef logic [17:0] ADDR_TP;

    localparam ADDR_TP IO_BASE     = 18'h30000;
    localparam ADDR_TP IO_CLK_ADDR = 18'h30004;

endpackage

// File: rtl/io_bridge_byte_fifo.sv
// rtl/io_bridge_byte_fifo.sv - byte FIFO with extra-MSB pointers for exact full/empty
module byte_fifo
    import io_bridge_pkg::*;
#(
    parameter int DEPTH_LOG = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  BYTE_TP             din,
    input  logic               pop,
    output BYTE_TP             head,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_LOG:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

    BYTE_TP             mem [DEPTH];
    logic [DEPTH_LOG:0] wr_ptr;
    logic [DEPTH_LOG:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                     (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
    assign count   = wr_ptr - rd_ptr;
    // Full is judged on the pre-pop state, so a push into a full FIFO is dropped even with a pop.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[DEPTH_LOG-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= din;
    end

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - CPU byte-bus bridge: RAM passthrough, UART FIFOs, clock counter, program stop
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int TX_DEPTH_LOG = 3,
    parameter int RX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] FULL_LEVEL = (TX_DEPTH_LOG+1)'(TX_DEPTH - FULL_MARGIN);

    ADDR_TP                addr;
    logic                  acc;
    logic                  io;
    logic                  rd_acc;
    logic                  wr_io;
    logic [31:0]           counter;
    logic [31:0]           snap;
    BYTE_TP                io_q;
    BYTE_TP                io_next;
    logic                  sel_io;

    logic                  tx_push;
    BYTE_TP                tx_data;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [TX_DEPTH_LOG:0] tx_count;
    logic [TX_DEPTH_LOG:0] tx_count_next;

    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    BYTE_TP                rx_head;
    logic [RX_DEPTH_LOG:0] unused_rx_count;
    logic                  unused_addr_hi;

    assign addr           = cpu_a[17:0];
    assign unused_addr_hi = ^cpu_a[31:18];
    assign acc            = rdy;
    assign io             = (addr[17:16] == 2'b11);
    assign rd_acc         = acc & ~cpu_wr;
    assign wr_io          = acc & cpu_wr & io & ~prog_stop;

    assign ram_a   = cpu_a[16:0];
    assign ram_din = cpu_dout;
    assign ram_we  = acc & cpu_wr & ~io;

    // The only way a 0x00 enters the TX FIFO is the stop write, so a popped 0x00 is the stop marker.
    always_comb begin
        tx_push = 1'b0;
        tx_data = cpu_dout;
        if (wr_io) begin
            if (addr == IO_BASE && cpu_dout != 8'h00) begin
                tx_push = 1'b1;
            end else if (addr == IO_CLK_ADDR) begin
                tx_push = 1'b1;
                tx_data = 8'h00;
            end
        end
    end

    assign tx_valid      = ~tx_empty;
    assign tx_pop        = tx_valid & tx_ready;
    assign tx_count_next = tx_count + {{TX_DEPTH_LOG{1'b0}}, tx_push & ~tx_full}
                                    - {{TX_DEPTH_LOG{1'b0}}, tx_pop};

    byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (tx_pop),
        .head  (tx_byte),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_acc & (addr == IO_BASE) & ~rx_empty;

    byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_byte),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (unused_rx_count)
    );

    always_comb begin
        io_next = 8'h00;
        case (addr)
            IO_BASE:              io_next = rx_empty ? 8'h00 : rx_head;
            IO_CLK_ADDR:          io_next = counter[7:0];
            IO_CLK_ADDR + 18'd1:  io_next = snap[15:8];
            IO_CLK_ADDR + 18'd2:  io_next = snap[23:16];
            IO_CLK_ADDR + 18'd3:  io_next = snap[31:24];
            default:              io_next = 8'h00;
        endcase
    end

    // sel_io resets to 1 with io_q = 0 so cpu_din reads 0 until the first access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter        <= '0;
            snap           <= '0;
            io_q           <= '0;
            sel_io         <= 1'b1;
            prog_stop      <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            counter        <= counter + 32'd1;
            io_buffer_full <= (tx_count_next >= FULL_LEVEL);
            if (tx_push & tx_full)          tx_overflow <= 1'b1;
            if (tx_pop && tx_byte == 8'h00) prog_stop   <= 1'b1;
            if (rd_acc) begin
                sel_io <= io;
                io_q   <= io_next;
                if (addr == IO_CLK_ADDR) snap <= counter;
            end
        end
    end

    assign cpu_din = sel_io ? io_q : ram_dout;

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - scoreboard bench for io_bridge
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] cpu_a = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_ready;
    logic        prog_stop;
    logic        tx_overflow;

    always #5 clk = ~clk;

    io_bridge dut (
        .clk(clk), .rst(rst), .rdy(rdy), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .prog_stop(prog_stop), .tx_overflow(tx_overflow)
    );

    logic [7:0] ram_mem [0:131071];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       ovf_model = 1'b0;
    logic       stop_model = 1'b0;
    logic       stop_chk = 1'b0;
    logic [31:0] mcnt;
    logic       rd_pend;
    logic [7:0] mon_e;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt    <= '0;
            rd_pend <= 1'b0;
        end else begin
            mcnt    <= mcnt + 32'd1;
            rd_pend <= rdy && !cpu_wr;
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (rd_pend) begin
                chk("rd_q_nonempty", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    mon_e = rd_q.pop_front();
                    chk("cpu_din", cpu_din, mon_e);
                end
            end
            if (stop_chk) begin
                chk("prog_stop_rise", prog_stop, 1);
                stop_chk = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                chk("tx_q_nonempty", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) begin
                    mon_e = tx_q.pop_front();
                    chk("tx_byte", tx_byte, mon_e);
                    if (mon_e == 8'h00) begin
                        chk("prog_stop_early", prog_stop, 0);
                        stop_chk   = 1'b1;
                        stop_model = 1'b1;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rdy = 1'b0; cpu_wr = 1'b0; rx_valid = 1'b0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        rdy = 1'b1; cpu_wr = 1'b1; cpu_a = a; cpu_dout = d; rx_valid = 1'b0;
        if (!stop_model && ((a[17:0] == 18'h30000 && d != 8'h00) || a[17:0] == 18'h30004)) begin
            if (tx_q.size() < 8) tx_q.push_back((a[17:0] == 18'h30004) ? 8'h00 : d);
            else ovf_model = 1'b1;
        end
    endtask

    task automatic rdx(input logic [31:0] a, input logic [7:0] e, input logic rv, input logic [7:0] rb);
        @(negedge clk);
        rdy = 1'b1; cpu_wr = 1'b0; cpu_a = a; rx_valid = rv; rx_byte = rb;
        rd_q.push_back(e);
    endtask

    task automatic rx_read(input logic rv, input logic [7:0] rb);
        logic [7:0] e;
        logic       can_push;
        can_push = rx_q.size() < 8;
        e = 8'h00;
        if (rx_q.size() != 0) e = rx_q.pop_front();
        if (rv && can_push) rx_q.push_back(rb);
        rdx(32'h30000, e, rv, rb);
    endtask

    task automatic rx_in(input logic [7:0] b);
        @(negedge clk);
        rdy = 1'b0; cpu_wr = 1'b0; rx_valid = 1'b1; rx_byte = b;
        chk("rx_ready", rx_ready, rx_q.size() < 8);
        if (rx_q.size() < 8) rx_q.push_back(b);
    endtask

    task automatic wait_tx_empty(input int limit);
        for (int i = 0; i < limit && !(tx_q.size() == 0 && !tx_valid); i++) @(negedge clk);
        chk("tx_drained", tx_q.size() == 0 && !tx_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_din"}, cpu_din, 8'h00);
        chk({tag, "_buf_full"}, io_buffer_full, 0);
        chk({tag, "_prog_stop"}, prog_stop, 0);
        chk({tag, "_tx_overflow"}, tx_overflow, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_rx_ready"}, rx_ready, 1);
        chk({tag, "_ram_we"}, ram_we, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] c;

        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // RAM passthrough
        wr(32'h00100, 8'h5A);
        #1 chk("ram_we_wr", ram_we, 1);
        chk("ram_a_wr", ram_a, 17'h00100);
        chk("ram_din_wr", ram_din, 8'h5A);
        wr(32'h2ABCD, 8'hC3);
        #1 chk("ram_a_hi", ram_a, 17'h0ABCD);
        chk("ram_we_hi", ram_we, 1);
        rdx(32'h00100, 8'h5A, 1'b0, 8'h00);
        #1 chk("ram_we_rd", ram_we, 0);
        rdx(32'h2ABCD, 8'hC3, 1'b0, 8'h00);
        wr(32'h30008, 8'h11);
        #1 chk("ram_we_io", ram_we, 0);
        @(negedge clk);
        rdy = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h00100;
        #1 chk("ram_we_nordy", ram_we, 0);
        idle(2);

        // TX basic, 0x00 data ignored
        wr(32'h30000, 8'h41);
        wr(32'h30000, 8'h42);
        wr(32'h30000, 8'h00);
        idle(1);
        chk("tx_valid_loaded", tx_valid, 1);
        chk("tx_head", tx_byte, 8'h41);
        tx_ready = 1'b1;
        wait_tx_empty(20);
        idle(2);
        chk("tx_valid_idle", tx_valid, 0);
        chk("no_stop", prog_stop, 0);
        tx_ready = 1'b0;

        // Backpressure and overflow
        for (int i = 0; i < 9; i++) begin
            wr(32'h30000, 8'h60 + 8'(i));
            chk("buf_full_fill", io_buffer_full, i >= 6);
            chk("tx_overflow_fill", tx_overflow, 0);
        end
        idle(1);
        chk("buf_full_8", io_buffer_full, 1);
        chk("tx_overflow", tx_overflow, ovf_model);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); tx_ready = 1'b1;
            @(negedge clk); tx_ready = 1'b0;
            chk("buf_full_drain", io_buffer_full, tx_q.size() >= 6);
        end
        tx_ready = 1'b1;
        wait_tx_empty(30);
        tx_ready = 1'b0;
        chk("buf_full_empty", io_buffer_full, 0);
        chk("tx_overflow_sticky", tx_overflow, 1);

        // Clock snapshot across a low-byte wrap
        for (int i = 0; i < 300 && mcnt[7:0] != 8'hFE; i++) @(negedge clk);
        chk("clk_align", mcnt[7:0], 8'hFE);
        c = mcnt + 32'd1;
        rdx(32'h30004, c[7:0],   1'b0, 8'h00);
        rdx(32'h30005, c[15:8],  1'b0, 8'h00);
        rdx(32'h30006, c[23:16], 1'b0, 8'h00);
        rdx(32'h30007, c[31:24], 1'b0, 8'h00);
        rdx(32'h30008, 8'h00,    1'b0, 8'h00);
        rdx(32'h30001, 8'h00,    1'b0, 8'h00);
        idle(1);

        // RX
        rx_in(8'h31);
        rx_in(8'h32);
        idle(1);
        repeat (3) rx_read(1'b0, 8'h00);
        idle(1);
        for (int i = 0; i < 9; i++) rx_in(8'h70 + 8'(i));
        idle(1);
        chk("rx_ready_full", rx_ready, 0);
        rx_read(1'b0, 8'h00);
        rx_read(1'b1, 8'h99);
        repeat (7) rx_read(1'b0, 8'h00);
        rx_read(1'b1, 8'hAB);
        rx_read(1'b0, 8'h00);
        rx_read(1'b0, 8'h00);
        idle(1);
        chk("rx_ready_empty", rx_ready, 1);

        // Stop
        tx_ready = 1'b1;
        wr(32'h30004, 8'h55);
        idle(1);
        for (int i = 0; i < 20 && !prog_stop; i++) @(negedge clk);
        chk("prog_stop", prog_stop, 1);
        wait_tx_empty(20);
        wr(32'h30000, 8'h77);
        wr(32'h30004, 8'h00);
        idle(3);
        chk("stop_tx_valid", tx_valid, 0);
        chk("stop_held", prog_stop, 1);

        // Reset clears stop, then reset mid-drain
        @(negedge clk);
        #1 rst = 1'b0;
        tx_q.delete(); rx_q.delete(); rd_q.delete();
        ovf_model = 1'b0; stop_model = 1'b0; stop_chk = 1'b0;
        #1 chk_reset_outputs("rst_stop");
        @(negedge clk);
        rst = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) wr(32'h30000, 8'h81 + 8'(i));
        rx_in(8'hE1);
        rx_in(8'hE2);
        rdx(32'h00100, 8'h5A, 1'b0, 8'h00);
        idle(1);
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst_buf_full", io_buffer_full, tx_q.size() >= 6);
        chk("pre_rst_cpu_din", cpu_din, 8'h5A);
        #1 rst = 1'b0;
        tx_q.delete(); rx_q.delete(); rd_q.delete();
        ovf_model = 1'b0; stop_model = 1'b0; stop_chk = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        chk("post_rst_tx_valid", tx_valid, 0);
        rx_read(1'b0, 8'h00);
        c = mcnt + 32'd1;
        rdx(32'h30004, c[7:0], 1'b0, 8'h00);
        wr(32'h30000, 8'h5E);
        idle(1);
        wait_tx_empty(20);
        chk("post_rst_buf_full", io_buffer_full, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
